// File: rtl/sao_stat_acc_n.sv
// SAO statistics collector: per-category signed diff sums and pixel counts over one block.
// Latency: a beat is visible on rd_sum/rd_cnt two cycles after it is presented; done two cycles after in_last.
// Backpressure: none; beats are always accepted in ACC. Macro SAO_STAT_SAT_EN makes accumulators saturate instead of wrap.
module sao_stat_acc_n #(
  parameter int PIX      = 4,
  parameter int DIFF_BIT = 4,
  parameter int CATE_BIT = 5,
  parameter int NCATE    = 32,
  parameter int ACC_BIT  = 18,
  parameter int CNT_BIT  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [PIX-1:0]             pix_en,
  input  logic [CATE_BIT-1:0]        cate [0:PIX-1],
  input  logic signed [DIFF_BIT:0]   diff [0:PIX-1],
  output logic                       busy,
  output logic                       done,
  output logic                       stat_valid,
  input  logic [CATE_BIT-1:0]        rd_idx,
  output logic signed [ACC_BIT-1:0]  rd_sum,
  output logic [CNT_BIT-1:0]         rd_cnt
);

  // Per-beat partial sum/count widths: PIX diffs and up to PIX pixels per category.
  localparam int S1W = DIFF_BIT + 1 + $clog2(PIX);
  localparam int C1W = $clog2(PIX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;
  logic   start_ok;
  logic   beat_ok;

  logic                  s1_vld;
  logic signed [S1W-1:0] s1_sum_d [NCATE];
  logic [C1W-1:0]        s1_cnt_d [NCATE];
  logic signed [S1W-1:0] s1_sum   [NCATE];
  logic [C1W-1:0]        s1_cnt   [NCATE];

  logic signed [ACC_BIT-1:0] acc_sum [NCATE];
  logic signed [ACC_BIT-1:0] sum_nxt [NCATE];
  logic [CNT_BIT-1:0]        acc_cnt [NCATE];
  logic [CNT_BIT-1:0]        cnt_nxt [NCATE];

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, start/beat acceptance and status outputs.
  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    beat_ok    = 1'b0;
    busy       = 1'b0;
    stat_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        busy = 1'b1;
        if (in_valid) begin
          beat_ok = 1'b1;
          if (in_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        stat_valid = 1'b1;
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_ACC;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // done pulses in the first DONE cycle, i.e. the cycle right after DRAIN.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == S_DRAIN);
  end

  // Stage 1 combinational: bin the beat's enabled pixels by category (out-of-range categories never match).
  always_comb begin
    for (int c = 0; c < NCATE; c++) begin
      s1_sum_d[c] = '0;
      s1_cnt_d[c] = '0;
      for (int i = 0; i < PIX; i++) begin
        if (pix_en[i] && (cate[i] == CATE_BIT'(c))) begin
          s1_sum_d[c] = s1_sum_d[c] + S1W'(diff[i]);
          s1_cnt_d[c] = s1_cnt_d[c] + C1W'(1);
        end
      end
    end
  end

  // Stage 1 registers: hold one beat's per-category partials for the accumulator stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      for (int c = 0; c < NCATE; c++) begin
        s1_sum[c] <= '0;
        s1_cnt[c] <= '0;
      end
    end else begin
      s1_vld <= beat_ok;
      if (beat_ok) begin
        for (int c = 0; c < NCATE; c++) begin
          s1_sum[c] <= s1_sum_d[c];
          s1_cnt[c] <= s1_cnt_d[c];
        end
      end
    end
  end

`ifdef SAO_STAT_SAT_EN
  // Widened adders keep the true sum so overflow can be detected and clamped.
  localparam int SW = ((ACC_BIT > S1W) ? ACC_BIT : S1W) + 1;
  localparam int CW = ((CNT_BIT > C1W) ? CNT_BIT : C1W) + 1;

  logic signed [SW-1:0] sum_wide [NCATE];
  logic [CW-1:0]        cnt_wide [NCATE];

  // Stage 2 next values with saturation at the signed/unsigned limits.
  always_comb begin
    for (int c = 0; c < NCATE; c++) begin
      sum_wide[c] = SW'(acc_sum[c]) + SW'(s1_sum[c]);
      cnt_wide[c] = CW'(acc_cnt[c]) + CW'(s1_cnt[c]);
      if (!sum_wide[c][SW-1] && (|sum_wide[c][SW-2:ACC_BIT-1]))
        sum_nxt[c] = {1'b0, {(ACC_BIT-1){1'b1}}};
      else if (sum_wide[c][SW-1] && !(&sum_wide[c][SW-2:ACC_BIT-1]))
        sum_nxt[c] = {1'b1, {(ACC_BIT-1){1'b0}}};
      else
        sum_nxt[c] = sum_wide[c][ACC_BIT-1:0];
      if (|cnt_wide[c][CW-1:CNT_BIT]) cnt_nxt[c] = '1;
      else                            cnt_nxt[c] = cnt_wide[c][CNT_BIT-1:0];
    end
  end
`else
  // Stage 2 next values, wrapping modulo the accumulator widths (sign-extended partial sums).
  always_comb begin
    for (int c = 0; c < NCATE; c++) begin
      sum_nxt[c] = acc_sum[c] + ACC_BIT'(s1_sum[c]);
      cnt_nxt[c] = acc_cnt[c] + CNT_BIT'(s1_cnt[c]);
    end
  end
`endif

  // Accumulators: cleared by reset or an accepted start, updated whenever stage 1 holds a beat.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      for (int c = 0; c < NCATE; c++) begin
        acc_sum[c] <= '0;
        acc_cnt[c] <= '0;
      end
    end else if (s1_vld) begin
      for (int c = 0; c < NCATE; c++) begin
        acc_sum[c] <= sum_nxt[c];
        acc_cnt[c] <= cnt_nxt[c];
      end
    end
  end

  // Readout: only needs a range check when rd_idx can address past the last category.
  if (NCATE < (1 << CATE_BIT)) begin : g_rd_chk
    // Combinational readout, zero for indices beyond NCATE.
    always_comb begin
      rd_sum = '0;
      rd_cnt = '0;
      if (rd_idx < CATE_BIT'(NCATE)) begin
        rd_sum = acc_sum[rd_idx];
        rd_cnt = acc_cnt[rd_idx];
      end
    end
  end else begin : g_rd_all
    // Combinational readout, every index is a valid category.
    always_comb begin
      rd_sum = acc_sum[rd_idx];
      rd_cnt = acc_cnt[rd_idx];
    end
  end

endmodule

// File: tb/tb_sao_stat_acc_n.sv
// Self-checking bench for sao_stat_acc_n: directed and random blocks against a per-beat arithmetic model.
// Latency: drives one beat per cycle and checks DRAIN/DONE timing two cycles after in_last.
// Backpressure: none; a 6-bit-accumulator instance shares all stimulus to expose overflow behaviour.
module tb_sao_stat_acc_n;

  localparam int NC = 32;
`ifdef SAO_STAT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic [3:0] pix_en;
  logic [5:0] cate [0:3];
  logic signed [4:0] diff [0:3];
  logic [5:0] rd_idx;
  logic busy, done, stat_valid;
  logic signed [17:0] rd_sum;
  logic [11:0] rd_cnt;
  logic busy6, done6, sv6;
  logic signed [5:0] rd_sum6;
  logic [11:0] rd_cnt6;

  int n_tests = 0;
  int n_fail  = 0;

  longint ref_sum [NC];
  longint ref6    [NC];
  longint ref_cnt [NC];
  int     ms;  // 0 idle, 1 accumulating, 3 finished (drain/done)

  always #5 clk = ~clk;

  sao_stat_acc_n #(.PIX(4), .DIFF_BIT(4), .CATE_BIT(6), .NCATE(32), .ACC_BIT(18), .CNT_BIT(12)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .pix_en(pix_en), .cate(cate), .diff(diff), .busy(busy), .done(done),
    .stat_valid(stat_valid), .rd_idx(rd_idx), .rd_sum(rd_sum), .rd_cnt(rd_cnt));

  sao_stat_acc_n #(.PIX(4), .DIFF_BIT(4), .CATE_BIT(6), .NCATE(32), .ACC_BIT(6), .CNT_BIT(12)) dut6 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .pix_en(pix_en), .cate(cate), .diff(diff), .busy(busy6), .done(done6),
    .stat_valid(sv6), .rd_idx(rd_idx), .rd_sum(rd_sum6), .rd_cnt(rd_cnt6));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fold_s(input longint v, input int w);
    longint hi, lo, m;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(hi + 1);
    if (SAT) return (v > hi) ? hi : ((v < lo) ? lo : v);
    m = v & ((longint'(1) << w) - 1);
    if (m > hi) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint fold_u(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (SAT) return (v > mx) ? mx : v;
    return v & mx;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NC; c++) begin
      ref_sum[c] = 0;
      ref6[c]    = 0;
      ref_cnt[c] = 0;
    end
  endtask

  task automatic model_beat();
    longint bs [NC];
    longint bc [NC];
    for (int c = 0; c < NC; c++) begin
      bs[c] = 0;
      bc[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (pix_en[i] && (int'(cate[i]) < NC)) begin
        bs[cate[i]] += longint'(diff[i]);
        bc[cate[i]] += 1;
      end
    end
    for (int c = 0; c < NC; c++) begin
      ref_sum[c] = fold_s(ref_sum[c] + bs[c], 18);
      ref6[c]    = fold_s(ref6[c] + bs[c], 6);
      ref_cnt[c] = fold_u(ref_cnt[c] + bc[c], 12);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] en, input int c0, input int c1, input int c2, input int c3,
                          input int d0, input int d1, input int d2, input int d3);
    pix_en  = en;
    cate[0] = 6'(c0); cate[1] = 6'(c1); cate[2] = 6'(c2); cate[3] = 6'(c3);
    diff[0] = 5'(d0); diff[1] = 5'(d1); diff[2] = 5'(d2); diff[3] = 5'(d3);
  endtask

  task automatic rand_beat();
    pix_en = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      cate[i] = 6'($urandom_range(0, 47));
      diff[i] = 5'($urandom);
    end
  endtask

  // Start pulse; a beat presented alongside an accepted start must be dropped.
  task automatic do_start(input bit with_beat);
    start    = 1'b1;
    in_valid = with_beat;
    in_last  = 1'b0;
    if (ms == 0 || ms == 3) begin
      clear_model();
      ms = 1;
    end else if (ms == 1 && with_beat) begin
      model_beat();
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drive_beat(input bit last);
    in_valid = 1'b1;
    in_last  = last;
    if (ms == 1) begin
      model_beat();
      if (last) ms = 3;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NC; c++) begin
      rd_idx = 6'(c);
      #1;
      chk($sformatf("%s.sum[%0d]", tag, c), rd_sum, ref_sum[c]);
      chk($sformatf("%s.cnt[%0d]", tag, c), rd_cnt, ref_cnt[c]);
      chk($sformatf("%s.sum6[%0d]", tag, c), rd_sum6, ref6[c]);
      chk($sformatf("%s.cnt6[%0d]", tag, c), rd_cnt6, ref_cnt[c]);
    end
    rd_idx = 6'd40;
    #1;
    chk({tag, ".sum_oor40"}, rd_sum, 0);
    chk({tag, ".cnt_oor40"}, rd_cnt, 0);
    rd_idx = 6'd63;
    #1;
    chk({tag, ".sum_oor63"}, rd_sum, 0);
    chk({tag, ".sum6_oor63"}, rd_sum6, 0);
  endtask

  // Called right after the in_last beat's edge: DUT is in DRAIN.
  task automatic finish_block(input string tag);
    chk({tag, ".drain_busy"}, busy, 1);
    chk({tag, ".drain_done"}, done, 0);
    tick();
    chk({tag, ".done"}, done, 1);
    chk({tag, ".done6"}, done6, 1);
    chk({tag, ".done_sv"}, stat_valid, 1);
    chk({tag, ".done_busy"}, busy, 0);
    tick();
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".sv_hold"}, stat_valid, 1);
    chk({tag, ".sv6_hold"}, sv6, 1);
    check_all(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nb;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; rd_idx = '0;
    set_beat(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    ms = 0;
    tick();
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sv", stat_valid, 0);
    chk("rst.busy6", busy6, 0);
    chk("rst.sum", rd_sum, 0);
    chk("rst.cnt", rd_cnt, 0);
    rst = 1'b0;
    tick();

    // Beats in IDLE are ignored.
    set_beat(4'hf, 3, 3, 3, 3, 5, 5, 5, 5);
    drive_beat(1'b1);
    tick();
    tick();
    chk("idle.busy", busy, 0);
    chk("idle.done", done, 0);
    rd_idx = 6'd3;
    #1;
    chk("idle.sum3", rd_sum, 0);

    // Basic block with an out-of-range category.
    do_start(1'b0);
    set_beat(4'b1111, 3, 3, 7, 40, 2, -5, 4, 1);
    drive_beat(1'b1);
    finish_block("basic");
    rd_idx = 6'd3;
    #1;
    chk("basic.sum3", rd_sum, -3);
    chk("basic.cnt3", rd_cnt, 2);
    rd_idx = 6'd7;
    #1;
    chk("basic.sum7", rd_sum, 4);
    chk("basic.cnt7", rd_cnt, 1);

    // Restart from DONE with a simultaneous beat: beat dropped, stats cleared.
    set_beat(4'hf, 0, 0, 0, 0, 7, 7, 7, 7);
    do_start(1'b1);
    chk("restart.sv", stat_valid, 0);
    chk("restart.busy", busy, 1);
    rd_idx = 6'd3;
    #1;
    chk("restart.sum3", rd_sum, 0);
    tick();
    rd_idx = 6'd0;
    #1;
    chk("restart.drop_sum0", rd_sum, 0);
    chk("restart.drop_cnt0", rd_cnt, 0);

    // Masking across beats, with an ignored start mid-block.
    set_beat(4'b0101, 0, 0, 0, 0, 1, 1, 1, 1);
    drive_beat(1'b0);
    drive_beat(1'b0);
    do_start(1'b0);
    chk("acc_start.busy", busy, 1);
    rd_idx = 6'd0;
    #1;
    chk("acc_start.sum0", rd_sum, 4);
    drive_beat(1'b1);
    finish_block("mask");
    rd_idx = 6'd0;
    #1;
    chk("mask.sum0", rd_sum, 6);
    chk("mask.cnt0", rd_cnt, 6);

    // Overflow of the narrow instance.
    do_start(1'b0);
    set_beat(4'hf, 1, 1, 1, 1, 15, 15, 15, 15);
    for (int k = 0; k < 8; k++) drive_beat(k == 7);
    finish_block("ovf");
    rd_idx = 6'd1;
    #1;
    chk("ovf.sum6", rd_sum6, SAT ? 31 : -32);
    chk("ovf.sum18", rd_sum, 480);
    chk("ovf.cnt", rd_cnt, 32);

    // Random blocks with occasional idle gaps.
    for (int b = 0; b < 8; b++) begin
      do_start(1'b0);
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          rand_beat();
          tick();
        end
        rand_beat();
        drive_beat(k == nb - 1);
      end
      finish_block($sformatf("rand%0d", b));
    end

    // Reset while in DRAIN.
    do_start(1'b0);
    set_beat(4'hf, 2, 2, 5, 9, 3, 4, -6, 7);
    drive_beat(1'b0);
    drive_beat(1'b1);
    chk("rstd.in_drain", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    ms = 0;
    chk("rstd.busy", busy, 0);
    chk("rstd.done", done, 0);
    chk("rstd.sv", stat_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rstd.nodone%0d", k), done, 0);
    end
    check_all("rstd");

    // After reset only a start does anything.
    rand_beat();
    drive_beat(1'b1);
    tick();
    tick();
    chk("rstd.idle_busy", busy, 0);
    check_all("rstd_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
